// File: rtl/chorus_pkg.sv
// Shared definitions for the multi-voice chorus: default sizes, FSM state
// encoding and the saturation helper used on the output mix.
package chorus_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_CTRL_W     = 12;
  localparam int DEF_PHASE_W    = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_MIX,
    ST_OUT
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                      input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/chorus_lfo.sv
// One chorus voice: phase accumulator whose triangle shape is mapped onto a
// tap delay spanning the upper half of the delay buffer.
module chorus_lfo
  import chorus_pkg::*;
#(
  parameter int                 ADDR_W     = DEF_ADDR_W,
  parameter int                 PHASE_W    = DEF_PHASE_W,
  parameter int                 CTRL_W     = DEF_CTRL_W,
  parameter logic [PHASE_W-1:0] INIT_PHASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic [CTRL_W-1:0] rate,
  output logic [ADDR_W-1:0] delay
);

  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-2:0]  tri_raw;
  logic [ADDR_W-2:0]  tri_val;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= INIT_PHASE;
    end else if (advance) begin
      phase <= phase + PHASE_W'(rate) + PHASE_W'(1);
    end
  end

  // Second half of the phase cycle mirrors the first, giving a triangle.
  assign tri_raw = phase[PHASE_W-2 -: ADDR_W-1];
  assign tri_val = phase[PHASE_W-1] ? ~tri_raw : tri_raw;
  assign delay   = {1'b1, tri_val};

endmodule

// File: rtl/chorus_multivoice.sv
// Mono-summed multi-voice chorus: each strobed sample is written to a delay
// line, NUM_VOICES modulated taps are summed, scaled and added/subtracted.
module chorus_multivoice
  import chorus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int PHASE_W    = DEF_PHASE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     VALID,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  input  logic        [CTRL_W-1:0] rate_slider,
  input  logic        [CTRL_W-1:0] mix_slider,
  input  logic                     bypass,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES);
  localparam int PROD_W = ACC_W + CTRL_W + 1;
  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

  state_t state, state_nxt;

  logic                     valid_q1, valid_q2, accept;
  logic signed [DATA_W-1:0] dry;
  logic        [CTRL_W-1:0] rate_lat, mix_lat;
  logic                     bypass_lat;
  logic        [ADDR_W-1:0] wr_ptr;
  logic        [ADDR_W:0]   fill_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic        [VIDX_W-1:0] vidx;

  logic signed [DATA_W:0]   in_sum;
  logic        [ADDR_W-1:0] voice_delay [NUM_VOICES];
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] mem [DEPTH];

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    wet;
  logic signed [ACC_W+1:0]  left_sum, right_sum;

  assign accept = valid_q1 & ~valid_q2;
  assign in_sum = (DATA_W+1)'(left_in) + (DATA_W+1)'(right_in);

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
    chorus_lfo #(
      .ADDR_W    (ADDR_W),
      .PHASE_W   (PHASE_W),
      .CTRL_W    (CTRL_W),
      .INIT_PHASE(PHASE_W'(longint'(k) * ((longint'(1) << PHASE_W) / NUM_VOICES)))
    ) u_lfo (
      .clk    (clk),
      .rst_n  (rst_n),
      .advance(state == ST_WRITE),
      .rate   (rate_lat),
      .delay  (voice_delay[k])
    );
  end

  // NOTE: the delay RAM has no reset; stale contents are masked by fill_cnt.
  always_ff @(posedge clk) begin
    if (state == ST_WRITE) mem[wr_ptr] <= dry;
  end

  assign rd_addr = wr_ptr - voice_delay[vidx];
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default first so no path through the case leaves state_nxt unassigned.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_READ;
      ST_READ:  if (vidx == LAST_V) state_nxt = ST_MIX;
      ST_MIX:   state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Wet path stays silent until every buffer slot holds a real sample.
  always_comb begin
    prod      = PROD_W'(acc) * PROD_W'($signed({1'b0, mix_lat}));
    wet       = (fill_cnt[ADDR_W] && !bypass_lat) ? (ACC_W+1)'(prod >>> CTRL_W) : '0;
    left_sum  = (ACC_W+2)'(dry) + (ACC_W+2)'(wet);
    right_sum = (ACC_W+2)'(dry) - (ACC_W+2)'(wet);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q1   <= 1'b0;
      valid_q2   <= 1'b0;
      dry        <= '0;
      rate_lat   <= '0;
      mix_lat    <= '0;
      bypass_lat <= 1'b0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      acc        <= '0;
      vidx       <= '0;
      left_out   <= '0;
      right_out  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid_q1  <= VALID;
      valid_q2  <= valid_q1;
      out_valid <= 1'b0;
      if (accept && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          dry        <= DATA_W'(in_sum >>> 1);
          rate_lat   <= rate_slider;
          mix_lat    <= mix_slider;
          bypass_lat <= bypass;
          acc        <= '0;
          vidx       <= '0;
        end
        ST_READ: begin
          acc  <= acc + ACC_W'(rd_data);
          vidx <= vidx + VIDX_W'(1);
        end
        ST_MIX: begin
          left_out  <= DATA_W'(sat_to_width(64'(left_sum), DATA_W));
          right_out <= DATA_W'(sat_to_width(64'(right_sum), DATA_W));
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (!fill_cnt[ADDR_W]) fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
